// File: rtl/scale_pkg.sv
// Shared types and helpers for the scale tare/calibration controller.
//   state_t     : controller FSM states
//   op_t        : which value an averaging run will commit
//   sat_to_width: clamp a signed value into a w-bit signed range
package scale_pkg;

    typedef enum logic [1:0] {IDLE, ACC_TARE, ACC_CAL, COMMIT} state_t;
    typedef enum logic {TARE_OP, CAL_OP} op_t;

    localparam int CAL_DEFAULT_C = 100000;

    // Works on 64-bit values so it can serve any DATA_W up to 63; callers
    // sign-extend on the way in and truncate on the way out.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Debouncer for one raw push button.
//   clk_100MHz  : system clock
//   rst_n       : async active-low reset (level resets to not-pressed)
//   btn_raw     : asynchronous, noisy button input
//   level       : debounced button level
//   press_pulse : one-cycle pulse on a debounced rising edge
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // Counter only advances while the synchronised input disagrees with the
    // accepted level; one agreeing cycle restarts the qualification window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                pulse_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level       = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/scale_zero_cal_ctrl.sv
// Tare / calibration capture for the HX711 scale front end.
// Debounced button presses start an averaging run over 2^AVG_LOG2 samples;
// the mean becomes TARE, or (mean - TARE) becomes CALIBRATE_VAL.
//   clk_100MHz, rst_n          : clock, async active-low reset
//   tare_button, calib_button  : raw buttons
//   DATA_VALID, RAW_VAL        : HX711 conversion strobe and reading
//   TARE, CALIBRATE_VAL        : committed zero offset and span
//   busy, done                 : run in progress, one-cycle success pulse
//   cal_err, timeout_err       : sticky status of the last run
module scale_zero_cal_ctrl
    import scale_pkg::*;
#(
    parameter int DATA_W          = 24,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AVG_LOG2        = 3,
    parameter int TIMEOUT_CYCLES  = 50_000_000,
    parameter int CAL_DEFAULT     = CAL_DEFAULT_C
) (
    input  logic                     clk_100MHz,
    input  logic                     rst_n,
    input  logic                     tare_button,
    input  logic                     calib_button,
    input  logic                     DATA_VALID,
    input  logic signed [DATA_W-1:0] RAW_VAL,
    output logic signed [DATA_W-1:0] TARE,
    output logic signed [DATA_W-1:0] CALIBRATE_VAL,
    output logic                     busy,
    output logic                     done,
    output logic                     cal_err,
    output logic                     timeout_err
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic tare_press, calib_press;
    logic tare_lvl_unused, calib_lvl_unused;  // levels not needed by this block

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tare_db (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_raw    (tare_button),
        .level      (tare_lvl_unused),
        .press_pulse(tare_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_calib_db (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_raw    (calib_button),
        .level      (calib_lvl_unused),
        .press_pulse(calib_press)
    );

    state_t                    state_q, state_d;
    op_t                       op_q, op_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [TO_W-1:0]           to_q, to_d;
    logic signed [DATA_W-1:0]  tare_q, tare_d;
    logic signed [DATA_W-1:0]  cal_q, cal_d;
    logic                      done_q, done_d;
    logic                      cal_err_q, cal_err_d;
    logic                      to_err_q, to_err_d;

    logic signed [DATA_W-1:0]  mean;
    logic signed [DATA_W:0]    span;
    logic signed [DATA_W-1:0]  span_sat;

    // Arithmetic shift floors toward -inf; the mean of DATA_W-bit samples
    // always fits back into DATA_W bits, so the truncation is lossless.
    assign mean     = DATA_W'(acc_q >>> AVG_LOG2);
    assign span     = (DATA_W+1)'(mean) - (DATA_W+1)'(tare_q);
    assign span_sat = DATA_W'(sat_to_width(64'(span), DATA_W));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        tare_d    = tare_q;
        cal_d     = cal_q;
        done_d    = 1'b0;
        cal_err_d = cal_err_q;
        to_err_d  = to_err_q;
        case (state_q)
            IDLE: begin
                // Tare has priority when both presses land together.
                if (tare_press || calib_press) begin
                    state_d   = tare_press ? ACC_TARE : ACC_CAL;
                    op_d      = tare_press ? TARE_OP : CAL_OP;
                    acc_d     = '0;
                    cnt_d     = '0;
                    to_d      = '0;
                    cal_err_d = 1'b0;
                    to_err_d  = 1'b0;
                end
            end
            ACC_TARE, ACC_CAL: begin
                if (DATA_VALID) begin
                    acc_d = acc_q + ACC_W'(RAW_VAL);
                    cnt_d = cnt_q + CNT_W'(1);
                    to_d  = '0;
                    if (cnt_q == CNT_W'(NSAMP - 1)) state_d = COMMIT;
                end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = IDLE;
                    to_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (op_q == TARE_OP) begin
                    tare_d = mean;
                    done_d = 1'b1;
                end else if (span_sat == '0) begin
                    cal_err_d = 1'b1;
                end else begin
                    cal_d  = span_sat;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= TARE_OP;
            acc_q     <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            tare_q    <= '0;
            cal_q     <= DATA_W'(CAL_DEFAULT);
            done_q    <= 1'b0;
            cal_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            tare_q    <= tare_d;
            cal_q     <= cal_d;
            done_q    <= done_d;
            cal_err_q <= cal_err_d;
            to_err_q  <= to_err_d;
        end
    end

    assign TARE          = tare_q;
    assign CALIBRATE_VAL = cal_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign cal_err       = cal_err_q;
    assign timeout_err   = to_err_q;

endmodule

// File: tb/tb_scale_zero_cal_ctrl.sv
module tb_scale_zero_cal_ctrl;

    localparam int DW = 24;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 tare_button, calib_button, dv;
    logic signed [DW-1:0] raw;
    logic signed [DW-1:0] tare, calv;
    logic                 busy, done, cal_err, to_err;

    always #5 clk = ~clk;

    scale_zero_cal_ctrl #(
        .DATA_W(DW), .DEBOUNCE_CYCLES(16), .AVG_LOG2(2),
        .TIMEOUT_CYCLES(100), .CAL_DEFAULT(100000)
    ) dut (
        .clk_100MHz(clk), .rst_n(rst_n),
        .tare_button(tare_button), .calib_button(calib_button),
        .DATA_VALID(dv), .RAW_VAL(raw),
        .TARE(tare), .CALIBRATE_VAL(calv),
        .busy(busy), .done(done), .cal_err(cal_err), .timeout_err(to_err)
    );

    typedef struct {
        bit is_tare;
        int s0, s1, s2, s3;
        int exp_tare, exp_cal;
        bit exp_done, exp_err;
    } vec_t;

    typedef struct { int tare; int cal; int cyc; } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every done pulse is captured for the scoreboard.
    always @(negedge clk)
        if (done === 1'b1) obs_q.push_back('{int'(tare), int'(calv), cyc});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Hold the selected button(s) for 20 cycles, enough to debounce at 16.
    task automatic press(input bit t, input bit c);
        bit seen = 0;
        tare_button  = t;
        calib_button = c;
        repeat (20) begin
            tick();
            if (busy) seen = 1;
        end
        tare_button  = 0;
        calib_button = 0;
        check("press_starts_op", seen, 1);
    endtask

    task automatic strobe(input int v);
        dv  = 1;
        raw = DW'(v);
        tick();
        dv  = 0;
    endtask

    // Four samples with two idle cycles between; returns the cycle of the last strobe.
    task automatic feed(input int a, input int b, input int c, input int d,
                        output int last_cyc);
        int s[4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            last_cyc = cyc;
            strobe(s[k]);
            if (k < 3) repeat (2) tick();
        end
    endtask

    task automatic drain_check(input string nm, input bit want);
        rec_t e, o;
        check({nm, "_done_count"}, obs_q.size(), want ? 1 : 0);
        if (want && obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({nm, "_sb_tare"}, o.tare, e.tare);
            check({nm, "_sb_cal"}, o.cal, e.cal);
            check({nm, "_latency"}, o.cyc - e.cyc, 2);
        end
        obs_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int  last;
        bit  ok;
        vecs[0] = '{1'b1, 100, 101, 102, 104, 101, 100000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, -5, -6, -6, -6, 101, -107, 1'b1, 1'b0};
        vecs[2] = '{1'b1, -8000000, -8000000, -8000000, -8000000, -8000000, -107, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8000000, 8000000, 8000000, 8000000, -8000000, 8388607, 1'b1, 1'b0};
        vecs[4] = '{1'b0, -8000000, -8000000, -8000000, -8000000, -8000000, 8388607, 1'b0, 1'b1};
        vecs[5] = '{1'b1, -3, -3, -2, -2, -3, 8388607, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 0, 0, 0, 1, -3, 3, 1'b1, 1'b0};

        rst_n = 0; tare_button = 0; calib_button = 0; dv = 0; raw = '0;
        repeat (3) tick();
        check("rst_tare", tare, 0);
        check("rst_cal", calv, 100000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cal_err", cal_err, 0);
        check("rst_to_err", to_err, 0);
        rst_n = 1;
        repeat (3) tick();

        // Short glitch must not register as a press.
        ok = 1;
        tare_button = 1;
        repeat (10) begin tick(); if (busy) ok = 0; end
        tare_button = 0;
        repeat (30) begin tick(); if (busy) ok = 0; end
        check("glitch_no_busy", ok, 1);
        check("glitch_tare", tare, 0);

        for (int i = 0; i < 7; i++) begin
            press(vecs[i].is_tare, !vecs[i].is_tare);
            feed(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, last);
            if (vecs[i].exp_done) exp_q.push_back('{vecs[i].exp_tare, vecs[i].exp_cal, last});
            repeat (4) tick();
            drain_check($sformatf("vec%0d", i), vecs[i].exp_done);
            check($sformatf("vec%0d_tare", i), tare, vecs[i].exp_tare);
            check($sformatf("vec%0d_cal", i), calv, vecs[i].exp_cal);
            check($sformatf("vec%0d_cal_err", i), cal_err, vecs[i].exp_err);
            check($sformatf("vec%0d_idle", i), busy, 0);
            repeat (20) tick();
        end

        // Both buttons together -> tare only; a calib press mid-run is dropped.
        press(1, 1);
        repeat (25) tick();
        ok = 1;
        calib_button = 1;
        repeat (20) begin tick(); if (!busy) ok = 0; end
        calib_button = 0;
        check("calib_in_acc_busy", ok, 1);
        feed(10, 10, 10, 10, last);
        exp_q.push_back('{10, 3, last});
        repeat (4) tick();
        drain_check("simul", 1);
        check("simul_tare", tare, 10);
        check("simul_cal", calv, 3);
        ok = 1;
        repeat (40) begin tick(); if (busy) ok = 0; end
        check("simul_no_second_op", ok, 1);
        check("simul_no_extra_done", obs_q.size(), 0);

        // Timeout: two samples then silence.
        press(0, 1);
        strobe(5);
        repeat (2) tick();
        strobe(6);
        repeat (99) tick();
        check("to_not_yet", to_err, 0);
        check("to_still_busy", busy, 1);
        tick();
        check("to_err_set", to_err, 1);
        check("to_idle", busy, 0);
        check("to_tare_kept", tare, 10);
        check("to_cal_kept", calv, 3);
        check("to_no_done", obs_q.size(), 0);
        repeat (25) tick();

        // Reset in the middle of a calibration run.
        press(0, 1);
        strobe(7);
        tick();
        check("mid_busy", busy, 1);
        rst_n = 0;
        #1;
        check("mrst_tare", tare, 0);
        check("mrst_cal", calv, 100000);
        check("mrst_busy", busy, 0);
        check("mrst_to_err", to_err, 0);
        repeat (3) tick();
        rst_n = 1;
        repeat (10) tick();
        check("mrst_idle", busy, 0);
        check("mrst_no_done", obs_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scale_zero_cal_ctrl.md
Name: scale_zero_cal_ctrl

Overview:
Parametrised successor to the scale's tare/calibration capture block. It debounces the tare and calibrate buttons in the single clk_100MHz domain, with no derived slow clock. Each operation averages 2^AVG_LOG2 consecutive HX711 conversions before committing. It also reports busy, done, zero-span and sensor-timeout status to the display/weight pipeline.

Parameters:
DATA_W, 24, width of signed raw sample, TARE and CALIBRATE_VAL
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz)
AVG_LOG2, 3, log2 of the number of samples averaged per operation (0 means a single sample)
TIMEOUT_CYCLES, 50_000_000, maximum idle cycles between DATA_VALID pulses while averaging
CAL_DEFAULT, 100000, reset value of CALIBRATE_VAL

Ports:
clk_100MHz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tare_button  in  1  raw asynchronous, noisy button
calib_button  in  1  raw asynchronous, noisy button
DATA_VALID  in  1  one-cycle strobe per HX711 conversion
RAW_VAL  in  DATA_W signed  raw reading, valid when DATA_VALID is high
TARE  out  DATA_W signed  stored zero offset
CALIBRATE_VAL  out  DATA_W signed  stored span (reference reading minus TARE)
busy  out  1  an averaging operation is in progress
done  out  1  one-cycle pulse on a successful commit
cal_err  out  1  sticky: last calibration had a zero span
timeout_err  out  1  sticky: last operation aborted because DATA_VALID stopped

Behaviour:
- Reset (async assert, sync release): TARE=0, CALIBRATE_VAL=CAL_DEFAULT, busy=0, done=0, cal_err=0, timeout_err=0, FSM=IDLE, debouncers report not-pressed. Reset mid-operation discards the accumulator; nothing is committed.
- Debounce per button:
  - 2-FF synchroniser feeds a stability counter.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles in which the synchronised input differs from the current debounced level. Any agreeing cycle clears the counter.
  - A rising edge of the debounced level produces a one-cycle press pulse. Release produces no pulse.
- FSM states: IDLE, ACC_TARE, ACC_CAL, COMMIT.
- IDLE:
  - Tare press goes to ACC_TARE; calib press goes to ACC_CAL.
  - Both pulses in the same cycle: tare wins and the calib press is dropped.
  - On entry to an ACC state: clear accumulator, sample count and timeout counter; clear cal_err and timeout_err.
- ACC_*:
  - busy=1. Press pulses are ignored.
  - On DATA_VALID: acc += sign-extended RAW_VAL, count++, timeout counter cleared.
  - The accumulator is DATA_W+AVG_LOG2 bits wide and cannot overflow.
  - When the 2^AVG_LOG2-th sample is accepted, the next state is COMMIT.
  - If the timeout counter reaches TIMEOUT_CYCLES, set timeout_err and return to IDLE with no commit.
- COMMIT (one cycle, busy=1):
  - mean = full accumulated sum >>> AVG_LOG2 (arithmetic shift, floor toward -inf).
  - Tare operation: TARE <= mean.
  - Calibrate operation: span = mean - TARE, computed in DATA_W+1 bits, then saturated to the DATA_W signed range.
    - span == 0: set cal_err; CALIBRATE_VAL unchanged; no done.
    - Otherwise: CALIBRATE_VAL <= span.
  - done pulses in the cycle after COMMIT only on a successful commit. The FSM then returns to IDLE.
- Registered outputs update in the cycle after COMMIT. Latency from the final accepted DATA_VALID to the updated output and done is 2 cycles.
- DATA_VALID in IDLE or COMMIT is ignored.

Decomposition:
- Package scale_pkg holds:
  - state enum: IDLE, ACC_TARE, ACC_CAL, COMMIT
  - op_t: TARE_OP, CAL_OP
  - saturation helper function
  - default CAL_DEFAULT constant
- Sub-module button_debounce (param DEBOUNCE_CYCLES; ports clk_100MHz, rst_n, btn_raw, level, press_pulse), instantiated twice.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=16, AVG_LOG2=2): tare glitch high for 10 cycles, then low → no press, TARE stays 0. Held high for 20 cycles → exactly one press.
- Tare averaging: RAW_VAL = 100, 101, 102, 104 on four DATA_VALIDs → TARE=101 (407>>>2), done pulses once, 2 cycles after the last strobe.
- Negative floor / calibration: with TARE=101, RAW_VAL = -5, -6, -6, -6 → mean=-6 (-23>>>2) → CALIBRATE_VAL=-107. Then TARE=-8000000 and samples 8000000 → span saturates to 8388607.
- Zero span: calibrate with all samples equal to TARE → cal_err=1, CALIBRATE_VAL unchanged, no done. cal_err clears on the next accepted press.
- Simultaneous presses / busy: both buttons debounce in the same cycle → tare op only. Calib press during ACC_TARE is ignored (busy stays 1, no second op).
- Timeout and reset: TIMEOUT_CYCLES=100, two samples then silence → timeout_err=1 at cycle 100, TARE unchanged. Separately, rst_n low mid-ACC_CAL → all outputs return to reset values immediately.
